// File: rtl/pacc_barrett_reduce_responder_pkg.sv
// Shared Kyber arithmetic constants for the PAcc reduce blocks (Barrett, Montgomery, poly-level).
// Internal widths for the Barrett pipeline are derived here so every user agrees on them.
package pacc_barrett_reduce_responder_pkg;

    localparam int KYBER_Q       = 3329;
    localparam int COEFF_W       = 16;
    localparam int BARRETT_V     = 20159;
    localparam int BARRETT_SHIFT = 26;

    // 16x16 signed product plus rounding constant fits comfortably in 32 bits
    localparam int PROD_W = 32;
    // quotient estimate spans -10..+10
    localparam int T_W    = 7;
    // a - t*Q evaluated wide enough to hold 32767 + 10*3329 before truncation
    localparam int RED_W  = 18;

endpackage

// File: rtl/pacc_barrett_reduce_responder.sv
// Responder for the PAcc coefficient-reduce handshake: 3-stage pipelined Barrett reduction
// returning the centred residue mod KYBER_Q with a done pulse 3 cycles after each enable.
module pacc_barrett_reduce_responder
    import pacc_barrett_reduce_responder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [COEFF_W-1:0] iCoeffs,
    output logic               BarrettR_done,
    output logic [COEFF_W-1:0] oCoeffs,
    output logic               busy
);

    localparam logic signed [PROD_W-1:0] V_P     = PROD_W'(BARRETT_V);
    localparam logic signed [PROD_W-1:0] ROUND_P = PROD_W'(longint'(1) << (BARRETT_SHIFT - 1));
    localparam logic signed [RED_W-1:0]  Q_R     = RED_W'(KYBER_Q);

    logic                      v1;
    logic                      v2;
    logic signed [COEFF_W-1:0] a1_r;
    logic signed [COEFF_W-1:0] a2_r;
    logic signed [PROD_W-1:0]  p_r;
    logic signed [T_W-1:0]     t_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            BarrettR_done <= 1'b0;
        end else begin
            v1            <= enable;
            v2            <= v1;
            BarrettR_done <= v2;
        end
    end

    // Data slices carry no reset; only the valid chain decides what reaches oCoeffs.
    always_ff @(posedge clk) begin
        a1_r <= iCoeffs;
        p_r  <= PROD_W'($signed(iCoeffs)) * V_P;
        a2_r <= a1_r;
        t_r  <= T_W'((p_r + ROUND_P) >>> BARRETT_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oCoeffs <= '0;
        end else if (v2) begin
            oCoeffs <= COEFF_W'(RED_W'(a2_r) - RED_W'(t_r) * Q_R);
        end
    end

    assign busy = v1 | v2 | BarrettR_done;

endmodule

// File: tb/tb_pacc_barrett_reduce_responder.sv
// Bench for pacc_barrett_reduce_responder: directed boundary/reset scenarios plus a
// randomized in-order scoreboard against a plain-arithmetic Barrett model.
module tb_pacc_barrett_reduce_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] iCoeffs;
    logic        BarrettR_done;
    logic [15:0] oCoeffs;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    pacc_barrett_reduce_responder dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .iCoeffs       (iCoeffs),
        .BarrettR_done (BarrettR_done),
        .oCoeffs       (oCoeffs),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input int a);
        longint t;
        t = (longint'(20159) * a + 64'sd33554432) >>> 26;
        return 16'(longint'(a) - t * 3329);
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        iCoeffs = 16'h1234;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (BarrettR_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b expected 0", BarrettR_done);
        end
        vectors++;
        if (oCoeffs !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_out: got %0d expected 0", $signed(oCoeffs));
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (BarrettR_done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset cycle %0d: done=%b busy=%b expected 0/0", i, BarrettR_done, busy);
            end
        end
    endtask

    task automatic test_single();
        iCoeffs = 16'd3329;
        enable  = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        iCoeffs = 16'h5a5a;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            vectors++;
            if (BarrettR_done !== (c == 3)) begin
                miscompares++;
                $display("FAIL single_latency cycle %0d: done=%b expected %b", c, BarrettR_done, (c == 3));
            end
        end
        vectors++;
        if (oCoeffs !== 16'd0) begin
            miscompares++;
            $display("FAIL single_value: got %0d expected 0", $signed(oCoeffs));
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            iCoeffs = 16'($urandom);
            vectors++;
            if (oCoeffs !== 16'd0 || BarrettR_done !== 1'b0) begin
                miscompares++;
                $display("FAIL single_hold cycle %0d: out=%0d done=%b expected 0/0", i, $signed(oCoeffs), BarrettR_done);
            end
        end
    endtask

    task automatic test_boundary();
        logic [15:0] ins  [5] = '{16'd1664, 16'd1665, 16'h8000, 16'h7fff, 16'hffff};
        logic [15:0] exps [5] = '{16'd1664, 16'hf980, 16'd522, 16'hfdf5, 16'hffff};
        for (int i = 0; i < 5; i++) begin
            iCoeffs = ins[i];
            enable  = 1'b1;
            @(negedge clk);
            enable  = 1'b0;
            repeat (2) @(negedge clk);
            vectors++;
            if (BarrettR_done !== 1'b1 || oCoeffs !== exps[i]) begin
                miscompares++;
                $display("FAIL boundary in=%0d: done=%b out=%0d expected done=1 out=%0d",
                         $signed(ins[i]), BarrettR_done, $signed(oCoeffs), $signed(exps[i]));
            end
            @(negedge clk);
            vectors++;
            if (BarrettR_done !== 1'b0) begin
                miscompares++;
                $display("FAIL boundary_pulse in=%0d: done=%b expected 0", $signed(ins[i]), BarrettR_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins  [4] = '{16'd100, 16'd3429, 16'hf363, 16'd6658};
        logic [15:0] exps [4] = '{16'd100, 16'd100, 16'd100, 16'd0};
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (BarrettR_done !== (c >= 3 && c <= 6)) begin
                miscompares++;
                $display("FAIL b2b_done cycle %0d: got %b expected %b", c, BarrettR_done, (c >= 3 && c <= 6));
            end else if (c >= 3 && c <= 6) begin
                vectors++;
                if (oCoeffs !== exps[c-3]) begin
                    miscompares++;
                    $display("FAIL b2b_value req %0d: got %0d expected %0d", c - 3, $signed(oCoeffs), $signed(exps[c-3]));
                end
            end
            enable  = (c < 4);
            iCoeffs = (c < 4) ? ins[c] : 16'h7777;
            @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        iCoeffs = 16'd1234;
        enable  = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (BarrettR_done !== 1'b1 || oCoeffs !== 16'd1234) begin
            miscompares++;
            $display("FAIL pre_reset_req: done=%b out=%0d expected 1/1234", BarrettR_done, $signed(oCoeffs));
        end
        @(negedge clk);
        iCoeffs = 16'd100;
        enable  = 1'b1;
        @(negedge clk);
        iCoeffs = 16'd5;
        @(negedge clk);
        enable  = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        vectors++;
        if (oCoeffs !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: out=%0d busy=%b expected 0/0", $signed(oCoeffs), busy);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (BarrettR_done !== 1'b0 || oCoeffs !== 16'd0) begin
                miscompares++;
                $display("FAIL reset_mid_flush cycle %0d: done=%b out=%0d expected 0/0", i, BarrettR_done, $signed(oCoeffs));
            end
            @(negedge clk);
        end
        iCoeffs = 16'd3330;
        enable  = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            vectors++;
            if (BarrettR_done !== (c == 3)) begin
                miscompares++;
                $display("FAIL post_reset_latency cycle %0d: done=%b expected %b", c, BarrettR_done, (c == 3));
            end
        end
        vectors++;
        if (oCoeffs !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_value: got %0d expected 1", $signed(oCoeffs));
        end
        @(negedge clk);
        vectors++;
        if (BarrettR_done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_pulse: done=%b expected 0", BarrettR_done);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [15:0] last_out = 16'd1;
        logic [15:0] expv;
        logic [2:0]  hist = 3'b000;
        int          n_en = 0;
        int          n_done = 0;
        int          cycles = 0;
        int          sel;
        logic        en;
        while ((n_en < 10000 && cycles < 40000) || hist != 3'b000) begin
            vectors++;
            if (BarrettR_done !== hist[2] || busy !== (|hist)) begin
                miscompares++;
                $display("FAIL rand_ctrl cycle %0d: done=%b busy=%b expected %b/%b",
                         cycles, BarrettR_done, busy, hist[2], |hist);
            end
            if (BarrettR_done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rand_spurious cycle %0d: done with empty scoreboard", cycles);
                end else begin
                    expv = exp_q.pop_front();
                    last_out = expv;
                    vectors++;
                    if (oCoeffs !== expv) begin
                        miscompares++;
                        $display("FAIL rand_value cycle %0d: got %0d expected %0d", cycles, $signed(oCoeffs), $signed(expv));
                    end
                end
            end else begin
                vectors++;
                if (oCoeffs !== last_out) begin
                    miscompares++;
                    $display("FAIL rand_hold cycle %0d: got %0d expected %0d", cycles, $signed(oCoeffs), $signed(last_out));
                end
            end
            en  = (n_en < 10000 && cycles < 40000) ? ($urandom_range(0, 2) != 0) : 1'b0;
            sel = int'($urandom_range(0, 15));
            iCoeffs = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7fff : 16'($urandom);
            enable  = en;
            if (en) begin
                n_en++;
                exp_q.push_back(model(int'($signed(iCoeffs))));
            end
            hist = {hist[1:0], en};
            cycles++;
            @(negedge clk);
        end
        enable = 1'b0;
        vectors++;
        if (n_done != n_en || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_count: done pulses %0d, enables %0d, left in scoreboard %0d", n_done, n_en, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
